// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, back-pressure and flush.
// Optional `ID_EX_STALL_COUNT_EN` adds a free-running count of load-use stall cycles.
module id_ex_stage_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_regf_we,
  input  logic            id_mem_read,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_regf_we,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic            load_use_stall
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  logic rs1_hit, rs2_hit, hz;
  logic load_bubble, capture;

  logic            valid_q, regf_we_q, mem_read_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_addr_q;

  // A bubble clears mem_read, so it can never create a hazard of its own.
  assign rs1_hit = id_rs1_used & (id_rs1_addr == rd_addr_q);
  assign rs2_hit = id_rs2_used & (id_rs2_addr == rd_addr_q);
  assign hz      = valid_q & mem_read_q & (rd_addr_q != 5'd0) & id_valid & (rs1_hit | rs2_hit);

  assign load_use_stall = hz;
  assign id_ready       = ex_ready & ~hz;

  always_comb begin
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (ex_ready) begin
      if (hz || !id_valid) begin
        load_bubble = 1'b1;
      end else begin
        capture = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      regf_we_q  <= 1'b0;
      mem_read_q <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (load_bubble) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      regf_we_q  <= 1'b0;
      mem_read_q <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (capture) begin
      valid_q    <= 1'b1;
      pc_q       <= id_pc;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
      rd_addr_q  <= id_rd_addr;
      regf_we_q  <= id_regf_we;
      mem_read_q <= id_mem_read;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_addr = rs1_addr_q;
  assign ex_rs2_addr = rs2_addr_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_regf_we  = regf_we_q;
  assign ex_mem_read = mem_read_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_count_q;

  // Counts only stalls that actually insert a bubble; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 32'd0;
    end else if (hz && ex_ready && !flush) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed per-cycle vectors with expected EX state.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_ready;
  logic [31:0] id_pc = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_regf_we = 1'b0, id_mem_read = 1'b0;
  logic [31:0] id_rs1_data = '0, id_rs2_data = '0;
  logic        ex_ready = 1'b1, flush = 1'b0;
  logic        ex_valid, ex_regf_we, ex_mem_read, load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [31:0] sc_act;
`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_count;
  assign sc_act = stall_count;
`else
  assign sc_act = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_regf_we(id_regf_we), .id_mem_read(id_mem_read),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_regf_we(ex_regf_we), .ex_mem_read(ex_mem_read),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .load_use_stall(load_use_stall)
`ifdef ID_EX_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        we, mr;
    logic [31:0] d1, d2;
    logic        rdy, st;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs for one cycle, applied just after the rising edge.
  task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                     input logic u1, input logic [4:0] a2, input logic u2,
                     input logic [4:0] rd, input logic we, input logic mr,
                     input logic [31:0] d1, input logic [31:0] d2,
                     input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_pc = pc; id_rs1_addr = a1; id_rs1_used = u1;
    id_rs2_addr = a2; id_rs2_used = u2; id_rd_addr = rd; id_regf_we = we;
    id_mem_read = mr; id_rs1_data = d1; id_rs2_data = d2; ex_ready = rdy; flush = fl;
  endtask

  task automatic idle(input logic rdy, input logic fl);
    drv(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, fl);
  endtask

  // Expected EX state and combinational outputs for the cycle just driven.
  task automatic ex(input logic ev, input logic [31:0] pc, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                    input logic mr, input logic [31:0] d1, input logic [31:0] d2,
                    input logic rdy, input logic st, input logic [31:0] sc);
    exp_t e;
    e.ev = ev; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we; e.mr = mr;
    e.d1 = d1; e.d2 = d2; e.rdy = rdy; e.st = st; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic bub(input logic rdy, input logic st, input logic [31:0] sc);
    ex(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, st, sc);
  endtask

  // Monitor: compares DUT state against the queued expectation each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.ev});
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rs1_addr", {27'd0, ex_rs1_addr}, {27'd0, e.rs1});
        chk("ex_rs2_addr", {27'd0, ex_rs2_addr}, {27'd0, e.rs2});
        chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
        chk("ex_regf_we", {31'd0, ex_regf_we}, {31'd0, e.we});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
        chk("ex_rs1_data", ex_rs1_data, e.d1);
        chk("ex_rs2_data", ex_rs2_data, e.d2);
        chk("id_ready", {31'd0, id_ready}, {31'd0, e.rdy});
        chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, e.st});
`ifdef ID_EX_STALL_COUNT_EN
        chk("stall_count", sc_act, e.sc);
`endif
      end
    end
  end

  initial begin
    #12 rst_n = 1'b1;
    idle(1'b1, 1'b0);                 bub(1'b1, 1'b0, 0);
    // addi x5, x1
    drv(1, 32'h100, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 32'h11, 32'h0, 1, 0);
    bub(1'b1, 1'b0, 0);
    // lw x6, (x2)
    drv(1, 32'h104, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 32'h22, 32'h0, 1, 0);
    ex(1, 32'h100, 5'd1, 5'd0, 5'd5, 1, 0, 32'h11, 32'h0, 1, 0, 0);
    // add x7, x6, x1: stalls one cycle
    drv(1, 32'h108, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 32'h33, 32'h44, 1, 0);
    ex(1, 32'h104, 5'd2, 5'd0, 5'd6, 1, 1, 32'h22, 32'h0, 0, 1, 0);
    drv(1, 32'h108, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 32'h33, 32'h44, 1, 0);
    bub(1'b1, 1'b0, 1);
    // lw x0
    drv(1, 32'h10c, 5'd3, 1, 5'd0, 0, 5'd0, 1, 1, 32'h55, 32'h0, 1, 0);
    ex(1, 32'h108, 5'd6, 5'd1, 5'd7, 1, 0, 32'h33, 32'h44, 1, 0, 1);
    // consumer of x0
    drv(1, 32'h110, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 32'h0, 32'h0, 1, 0);
    ex(1, 32'h10c, 5'd3, 5'd0, 5'd0, 1, 1, 32'h55, 32'h0, 1, 0, 1);
    // lw x6, then rs2=6 but unused
    drv(1, 32'h114, 5'd4, 1, 5'd0, 0, 5'd6, 1, 1, 32'h66, 32'h0, 1, 0);
    ex(1, 32'h110, 5'd0, 5'd0, 5'd8, 1, 0, 32'h0, 32'h0, 1, 0, 1);
    drv(1, 32'h118, 5'd5, 1, 5'd6, 0, 5'd9, 1, 0, 32'h77, 32'h88, 1, 0);
    ex(1, 32'h114, 5'd4, 5'd0, 5'd6, 1, 1, 32'h66, 32'h0, 1, 0, 1);
    // back-pressure for three cycles, then flush while still back-pressured
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h11c, 5'd1, 1, 5'd0, 0, 5'd10, 1, 0, 32'h99, 32'h0, 0, (i == 3));
      ex(1, 32'h118, 5'd5, 5'd6, 5'd9, 1, 0, 32'h77, 32'h88, 0, 0, 1);
    end
    idle(1'b1, 1'b0);                 bub(1'b1, 1'b0, 1);
    // hazard under back-pressure holds; stall persists until ex_ready returns
    drv(1, 32'h200, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 32'haa, 32'h0, 1, 0);
    bub(1'b1, 1'b0, 1);
    drv(1, 32'h204, 5'd0, 0, 5'd6, 1, 5'd11, 1, 0, 32'h0, 32'hbb, 0, 0);
    ex(1, 32'h200, 5'd1, 5'd0, 5'd6, 1, 1, 32'haa, 32'h0, 0, 1, 1);
    drv(1, 32'h204, 5'd0, 0, 5'd6, 1, 5'd11, 1, 0, 32'h0, 32'hbb, 1, 0);
    ex(1, 32'h200, 5'd1, 5'd0, 5'd6, 1, 1, 32'haa, 32'h0, 0, 1, 1);
    drv(1, 32'h204, 5'd0, 0, 5'd6, 1, 5'd11, 1, 0, 32'h0, 32'hbb, 1, 0);
    bub(1'b1, 1'b0, 2);
    // flush and hazard together: flush wins and the stall is not counted
    drv(1, 32'h208, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 32'hcc, 32'h0, 1, 0);
    ex(1, 32'h204, 5'd0, 5'd6, 5'd11, 1, 0, 32'h0, 32'hbb, 1, 0, 2);
    drv(1, 32'h20c, 5'd6, 1, 5'd0, 0, 5'd12, 1, 0, 32'hdd, 32'h0, 1, 1);
    ex(1, 32'h208, 5'd2, 5'd0, 5'd6, 1, 1, 32'hcc, 32'h0, 0, 1, 2);
    idle(1'b1, 1'b0);                 bub(1'b1, 1'b0, 2);
    // reset asserted during a hazard cycle
    drv(1, 32'h300, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 32'hee, 32'h0, 1, 0);
    bub(1'b1, 1'b0, 2);
    drv(1, 32'h304, 5'd6, 1, 5'd0, 0, 5'd13, 1, 0, 32'h0, 32'h0, 1, 0);
    ex(1, 32'h300, 5'd1, 5'd0, 5'd6, 1, 1, 32'hee, 32'h0, 0, 1, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_load_use_stall", {31'd0, load_use_stall}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
`ifdef ID_EX_STALL_COUNT_EN
    chk("rst_stall_count", sc_act, 32'd0);
`endif
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
